// File: rtl/gnrl_fifo_vr_pkg.sv
// rtl/gnrl_fifo_vr_pkg.sv - shared sizing helpers for the valid/ready FIFO
package gnrl_fifo_vr_pkg;

  // A single-entry FIFO still needs a 1-bit pointer to keep the port legal.
  function automatic int ptr_width(input int dp);
    return (dp > 1) ? $clog2(dp) : 1;
  endfunction

endpackage

// File: rtl/gnrl_dffl.sv
// rtl/gnrl_dffl.sv - load-enable DFF cell without reset
module gnrl_dffl #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  always_ff @(posedge clk) begin
    if (lden) qout <= dnxt;
  end

endmodule

// File: rtl/gnrl_dfflr.sv
// rtl/gnrl_dfflr.sv - load-enable DFF cell with synchronous active-high reset to zero
module gnrl_dfflr #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  always_ff @(posedge clk) begin
    if (rst)       qout <= '0;
    else if (lden) qout <= dnxt;
  end

endmodule

// File: rtl/gnrl_fifo_ptr.sv
// rtl/gnrl_fifo_ptr.sv - wrapping FIFO pointer, counts 0..DP-1 on each inc
module gnrl_fifo_ptr
  import gnrl_fifo_vr_pkg::*;
#(
  parameter int DP = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inc,
  output logic [ptr_width(DP)-1:0] ptr
);

  localparam int PW = ptr_width(DP);

  logic [PW-1:0] ptr_nxt;

  // DP need not be a power of two, so wrap explicitly rather than by overflow.
  always_comb begin
    ptr_nxt = (ptr == PW'(DP - 1)) ? '0 : ptr + 1'b1;
  end

  gnrl_dfflr #(.DW(PW)) u_ptr (
    .clk  (clk),
    .rst  (rst),
    .lden (inc),
    .dnxt (ptr_nxt),
    .qout (ptr)
  );

endmodule

// File: rtl/gnrl_fifo_vr.sv
// rtl/gnrl_fifo_vr.sv - synchronous valid/ready FIFO built from load-enable DFFs
module gnrl_fifo_vr
  import gnrl_fifo_vr_pkg::*;
#(
  parameter int DW        = 32,
  parameter int DP        = 4,
  parameter bit CUT_READY = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_vld,
  output logic                     i_rdy,
  input  logic [DW-1:0]            i_dat,
  output logic                     o_vld,
  input  logic                     o_rdy,
  output logic [DW-1:0]            o_dat,
  output logic [$clog2(DP+1)-1:0]  cnt
);

  localparam int PW = ptr_width(DP);
  localparam int CW = $clog2(DP + 1);

  logic          push;
  logic          pop;
  logic          full;
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [CW-1:0] cnt_nxt;
  logic [DW-1:0] mem [DP];

  always_comb begin
    full  = (cnt == CW'(DP));
    o_vld = (cnt != '0);
    // With CUT_READY=0 a full FIFO may take a push into the slot being popped.
    i_rdy = CUT_READY ? !full : (!full || o_rdy);
    push  = i_vld && i_rdy;
    pop   = o_vld && o_rdy;
    cnt_nxt = push ? cnt + 1'b1 : cnt - 1'b1;
    o_dat = mem[rptr];
  end

  gnrl_fifo_ptr #(.DP(DP)) u_rptr (
    .clk (clk),
    .rst (rst),
    .inc (pop),
    .ptr (rptr)
  );

  gnrl_fifo_ptr #(.DP(DP)) u_wptr (
    .clk (clk),
    .rst (rst),
    .inc (push),
    .ptr (wptr)
  );

  gnrl_dfflr #(.DW(CW)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .lden (push ^ pop),
    .dnxt (cnt_nxt),
    .qout (cnt)
  );

  for (genvar k = 0; k < DP; k++) begin : g_mem
    gnrl_dffl #(.DW(DW)) u_ent (
      .clk  (clk),
      .lden (push && (wptr == PW'(k))),
      .dnxt (i_dat),
      .qout (mem[k])
    );
  end

endmodule

// File: tb/tb_gnrl_fifo_vr.sv
// tb/tb_gnrl_fifo_vr.sv - self-checking bench for gnrl_fifo_vr across depths and ready modes
module tb_gnrl_fifo_vr;

  localparam int N = 4;
  localparam int DP_OF [N] = '{4, 4, 3, 1};
  localparam bit CR_OF [N] = '{1'b0, 1'b1, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       rst;
  logic       vld  [N];
  logic       ordy [N];
  logic [7:0] dat  [N];
  logic       irdy [N];
  logic       ovld [N];
  logic [7:0] odat [N];
  logic [2:0] c0;
  logic [2:0] c1;
  logic [1:0] c2;
  logic [0:0] c3;

  logic [7:0] mq [N][$];
  bit         known [N];
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  gnrl_fifo_vr #(.DW(8), .DP(4), .CUT_READY(1'b0)) u_d4c0 (
    .clk(clk), .rst(rst), .i_vld(vld[0]), .i_rdy(irdy[0]), .i_dat(dat[0]),
    .o_vld(ovld[0]), .o_rdy(ordy[0]), .o_dat(odat[0]), .cnt(c0));
  gnrl_fifo_vr #(.DW(8), .DP(4), .CUT_READY(1'b1)) u_d4c1 (
    .clk(clk), .rst(rst), .i_vld(vld[1]), .i_rdy(irdy[1]), .i_dat(dat[1]),
    .o_vld(ovld[1]), .o_rdy(ordy[1]), .o_dat(odat[1]), .cnt(c1));
  gnrl_fifo_vr #(.DW(8), .DP(3), .CUT_READY(1'b0)) u_d3c0 (
    .clk(clk), .rst(rst), .i_vld(vld[2]), .i_rdy(irdy[2]), .i_dat(dat[2]),
    .o_vld(ovld[2]), .o_rdy(ordy[2]), .o_dat(odat[2]), .cnt(c2));
  gnrl_fifo_vr #(.DW(8), .DP(1), .CUT_READY(1'b0)) u_d1c0 (
    .clk(clk), .rst(rst), .i_vld(vld[3]), .i_rdy(irdy[3]), .i_dat(dat[3]),
    .o_vld(ovld[3]), .o_rdy(ordy[3]), .o_dat(odat[3]), .cnt(c3));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int i);
    case (i)
      0:       return 32'(c0);
      1:       return 32'(c1);
      2:       return 32'(c2);
      default: return 32'(c3);
    endcase
  endfunction

  // Reference: a queue per instance; outputs compared at negedge, handshakes applied at the next posedge.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      int sz;
      bit e_ovld;
      bit e_irdy;
      sz     = mq[i].size();
      e_ovld = (sz > 0);
      e_irdy = (sz < DP_OF[i]) || (!CR_OF[i] && ordy[i]);
      if (known[i]) begin
        check_eq($sformatf("i%0d_ovld", i), 32'(ovld[i]), 32'(e_ovld));
        check_eq($sformatf("i%0d_irdy", i), 32'(irdy[i]), 32'(e_irdy));
        check_eq($sformatf("i%0d_cnt", i), cnt_of(i), 32'(sz));
        check_eq($sformatf("i%0d_cnt_le_dp", i), 32'(cnt_of(i) <= 32'(DP_OF[i])), 32'd1);
        if (e_ovld) check_eq($sformatf("i%0d_odat", i), 32'(odat[i]), 32'(mq[i][0]));
      end
      if (rst) begin
        mq[i].delete();
        known[i] = 1'b1;
      end else if (known[i]) begin
        if (e_ovld && ordy[i]) void'(mq[i].pop_front());
        if (vld[i] && e_irdy) mq[i].push_back(dat[i]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    bit acc;
    for (int i = 0; i < N; i++) begin
      vld[i] = 1'b0; ordy[i] = 1'b0; dat[i] = '0; known[i] = 1'b0;
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_ovld0", 32'(ovld[0]), 32'd0);
    check_eq("rst_irdy1", 32'(irdy[1]), 32'd1);
    check_eq("rst_cnt0", 32'(c0), 32'd0);

    // Fill DP=4 in both ready modes with the consumer stalled.
    for (int k = 0; k < 4; k++) begin
      vld[0] = 1'b1; vld[1] = 1'b1;
      dat[0] = 8'hA0 + 8'(k); dat[1] = 8'hA0 + 8'(k);
      tick();
      check_eq("fill_cnt", 32'(c0), 32'(k + 1));
      check_eq("fill_head", 32'(odat[0]), 32'hA0);
    end
    vld[0] = 1'b0; vld[1] = 1'b0;
    #1;
    check_eq("full_irdy0", 32'(irdy[0]), 32'd0);
    check_eq("full_irdy1", 32'(irdy[1]), 32'd0);

    // Push and pop together while full.
    vld[0] = 1'b1; vld[1] = 1'b1; ordy[0] = 1'b1; ordy[1] = 1'b1;
    dat[0] = 8'hB0; dat[1] = 8'hB0;
    #1;
    check_eq("fullpp_irdy_cr0", 32'(irdy[0]), 32'd1);
    check_eq("fullpp_irdy_cr1", 32'(irdy[1]), 32'd0);
    tick();
    vld[0] = 1'b0; vld[1] = 1'b0;
    check_eq("fullpp_cnt_cr0", 32'(c0), 32'd4);
    check_eq("fullpp_cnt_cr1", 32'(c1), 32'd3);
    check_eq("fullpp_head_cr0", 32'(odat[0]), 32'hA1);
    for (int k = 0; k < 5; k++) tick();
    check_eq("drain_ovld", 32'(ovld[0]), 32'd0);
    check_eq("drain_cnt", 32'(c0), 32'd0);
    ordy[0] = 1'b0; ordy[1] = 1'b0;

    // Push and pop together while empty: no bypass.
    vld[0] = 1'b1; ordy[0] = 1'b1; dat[0] = 8'h55;
    #1;
    check_eq("emptypp_ovld_n", 32'(ovld[0]), 32'd0);
    tick();
    vld[0] = 1'b0;
    #1;
    check_eq("emptypp_ovld_n1", 32'(ovld[0]), 32'd1);
    check_eq("emptypp_odat_n1", 32'(odat[0]), 32'h55);
    tick();
    check_eq("emptypp_cnt_n2", 32'(c0), 32'd0);
    ordy[0] = 1'b0;

    // DP=3 wrap-around with a toggling consumer; producer holds until accepted.
    sent = 0;
    for (int cyc = 0; cyc < 200 && sent < 10; cyc++) begin
      vld[2] = 1'b1; dat[2] = 8'(sent); ordy[2] = (cyc % 2 == 0);
      #1;
      acc = irdy[2];
      tick();
      if (acc) sent++;
    end
    check_eq("wrap_sent", 32'(sent), 32'd10);
    vld[2] = 1'b0; ordy[2] = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check_eq("wrap_drained", 32'(c2), 32'd0);
    ordy[2] = 1'b0;

    // Reset in the middle of operation with a push pending.
    vld[0] = 1'b1;
    dat[0] = 8'hC0; tick();
    dat[0] = 8'hC1; tick();
    check_eq("midrst_pre_cnt", 32'(c0), 32'd2);
    rst = 1'b1; dat[0] = 8'hC2;
    tick();
    rst = 1'b0; vld[0] = 1'b0;
    #1;
    check_eq("midrst_cnt", 32'(c0), 32'd0);
    check_eq("midrst_ovld", 32'(ovld[0]), 32'd0);
    check_eq("midrst_irdy", 32'(irdy[0]), 32'd1);
    tick();
    check_eq("midrst_cnt_hold", 32'(c0), 32'd0);

    // DP=1 single-entry alternation.
    for (int k = 0; k < 6; k++) begin
      vld[3] = (k % 2 == 0); ordy[3] = (k % 2 == 1); dat[3] = 8'h30 + 8'(k);
      tick();
      check_eq("dp1_cnt", 32'(c3), (k % 2 == 0) ? 32'd1 : 32'd0);
    end

    // Randomized traffic on all instances with occasional resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        vld[i]  = ($urandom_range(0, 3) != 0);
        ordy[i] = ($urandom_range(0, 2) != 0) ^ (cyc[8]);
        dat[i]  = 8'($urandom);
      end
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gnrl_fifo_vr.md
Name: gnrl_fifo_vr

Overview:
- Parameterised synchronous FIFO with valid/ready handshakes on both sides.
- Sits between a producer stage and the general DFF-based pipeline registers (load-enable DFFs) downstream.
- Absorbs back-pressure so upstream stages can keep issuing while the consumer stalls.
- Storage and pointer state are built from load-enable flops; one clock domain.

Parameters:
- DW, 32, data width in bits (≥1).
- DP, 4, depth in entries (≥1; need not be a power of two).
- CUT_READY, 0, 1 = i_rdy depends only on internal state (no combinational o_rdy→i_rdy path); 0 = a full FIFO accepts a push in the same cycle as a pop.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- i_vld  input  1  upstream data valid.
- i_rdy  output  1  FIFO can accept i_dat this cycle.
- i_dat  input  DW  upstream data.
- o_vld  output  1  head entry valid.
- o_rdy  input  1  downstream accepts head this cycle.
- o_dat  output  DW  head entry data.
- cnt  output  $clog2(DP+1)  number of occupied entries.

Behaviour:
- Reset: rst=1 at a rising edge clears rptr=0, wptr=0, cnt=0. From the next cycle o_vld=0. i_rdy=1 in both modes. Storage array is not reset.
- o_dat is don't-care while o_vld=0. The bench must not check it then.
- Reset mid-operation discards all entries. Handshakes in the reset cycle have no effect.
- push = i_vld & i_rdy; pop = o_vld & o_rdy. Both are evaluated combinationally in the same cycle.
- full = (cnt==DP); empty = (cnt==0); o_vld = !empty.
- i_rdy = !full when CUT_READY=1.
- i_rdy = !full | o_rdy when CUT_READY=0.
- o_dat = mem[rptr]. Combinational read, registered storage.
- Latency: a push in cycle N makes the entry visible on o_vld/o_dat in cycle N+1. No same-cycle bypass from an empty FIFO.
- push: mem[wptr] <= i_dat; wptr <= (wptr==DP-1) ? 0 : wptr+1.
- pop: rptr <= (rptr==DP-1) ? 0 : rptr+1.
- cnt: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop:
  - Empty: pop is impossible (o_vld=0), so only the push takes effect.
  - Full with CUT_READY=0: both take effect; the write lands in the slot freed by the wrapped wptr==rptr, cnt stays DP.
  - Full with CUT_READY=1: the push is refused.
- Ordering: strict FIFO; no drops, no duplicates.
- DP=1: pointers are constant 0 and only cnt toggles; behaves as a single-entry skid register.
- i_vld while i_rdy=0 is ignored. The producer must hold it; the FIFO does not latch it.
- Assertions (bench side):
  - cnt ≤ DP.
  - No push when full unless a pop occurs in the same cycle (CUT_READY=0).
  - No pop when empty.

Decomposition:
- Shared header/package: none required.
- Width helper: pointer width = (DP>1) ? $clog2(DP) : 1, computed as a localparam.
- Sub-module gnrl_fifo_ptr holds one wrapping pointer:
  - Inputs: clk, rst, inc.
  - Output: ptr.
  - Parameter: DP.
  - Wraps at DP-1.
  - Instantiated twice (rptr, wptr).
- The storage array and cnt register use the team's general load-enable DFF cells (per-entry load enable = push & (wptr==k)).

Test Plan:
- Reset then fill, DP=4, CUT_READY=0, o_rdy=0:
  - Push 0xA0,0xA1,0xA2,0xA3 on consecutive cycles → cnt 1,2,3,4; i_rdy=0 after the 4th.
  - o_vld=1 with o_dat=0xA0 from the cycle after the first push.
- Drain:
  - From full, hold o_rdy=1, i_vld=0 → o_dat sequence 0xA0..0xA3, one per cycle; o_vld=0 and cnt=0 after 4 cycles.
- Full simultaneous push/pop, CUT_READY=0 vs 1:
  - Full with i_vld=1, o_rdy=1, i_dat=0xB0.
  - CUT_READY=0 → i_rdy=1, cnt stays 4, 0xB0 emerges after 0xA1..0xA3.
  - CUT_READY=1 → i_rdy=0, cnt drops to 3, 0xB0 not accepted that cycle.
- Wrap-around with non-power-of-2 depth (DP=3):
  - Stream 10 words 0..9 with o_rdy toggling 1,0,1,0…
  - → outputs exactly 0..9 in order; pointers cycle 0,1,2,0; cnt never exceeds 3.
- Empty simultaneous push/pop:
  - cnt=0, i_vld=1, o_rdy=1, i_dat=0x55 → cycle N: o_vld=0.
  - Cycle N+1: o_vld=1, o_dat=0x55; pop completes, cnt returns to 0 at N+2.
- Reset mid-operation:
  - With cnt=2, assert rst for 1 cycle while i_vld=1 → next cycle cnt=0, o_vld=0, i_rdy=1; the pushed data is not retained.
  - DP=1 repeat → single-entry push/pop alternates with cnt 0↔1.
